// File: rtl/xadc_pkg.sv
// rtl/xadc_pkg.sv - shared types and constants for the XADC DRP sampler
//
// Contents:
//   xadc_drp_addr_t  - DRP result-register addresses used on this board
//   sampler_state_t  - sequencer states
//   XADC_RESULT_MSB  - top bit of the 12-bit result inside the 16-bit DRP word
//   XADC_RESULT_BITS - width of an XADC conversion result
//   ch_width()       - width of a channel index for a given channel count
package xadc_pkg;

  typedef enum logic [6:0] {
    XADC_ADDR_TEMP   = 7'h00,
    XADC_ADDR_VCCINT = 7'h01,
    XADC_ADDR_VAUX4  = 7'h14,  // current sense
    XADC_ADDR_VAUX12 = 7'h1c   // voltage sense
  } xadc_drp_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DRDY,
    SEND
  } sampler_state_t;

  localparam int XADC_RESULT_MSB  = 15;
  localparam int XADC_RESULT_BITS = 12;

  // A single-channel sequencer still needs a 1-bit index register.
  function automatic int ch_width(input int num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

endpackage

// File: rtl/xadc_drp_sampler_sat_counter.sv
// rtl/xadc_drp_sampler_sat_counter.sv - saturating event counter
//
// Ports:
//   clk    in          clock
//   rst_n  in          asynchronous active-low reset, clears the count
//   inc    in          add one this cycle
//   count  out [W-1:0] current count, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/xadc_drp_sampler.sv
// rtl/xadc_drp_sampler.sv - multi-channel XADC DRP read sequencer with AXIS output
//
// On every XADC end-of-sequence pulse, reads NUM_CHANNELS result registers
// over DRP in table order and emits one channel-tagged beat per result:
//   m_axis_tdata = {channel_index[3:0], sample zero-extended to 12 bits}
//
// Optional build macro XADC_SAMPLER_TLAST_EN: when defined, m_axis_tlast
// marks the last channel of each sequence; otherwise it is tied low.
//
// Ports:
//   clk            in   DRP / stream clock (same as xadc_wiz_0 dclk_in)
//   rst_n          in   asynchronous active-low reset
//   enable         in   gate for starting new sequences
//   xadc_eos       in   end-of-sequence pulse from the XADC
//   xadc_daddr     out  DRP address
//   xadc_den       out  DRP enable, one-cycle pulse per read
//   xadc_drdy      in   DRP read data valid
//   xadc_do        in   DRP read data
//   m_axis_tdata   out  channel-tagged sample
//   m_axis_tvalid  out  stream valid
//   m_axis_tready  in   stream ready
//   m_axis_tlast   out  last beat of a sequence (optional)
//   overrun_count  out  EOS pulses dropped while busy, saturating
//   timeout_count  out  DRP reads aborted for lack of drdy, saturating
//   busy           out  sequencer not idle
module xadc_drp_sampler
  import xadc_pkg::*;
#(
  parameter int                          NUM_CHANNELS  = 2,
  parameter int                          SAMPLE_WIDTH  = 12,
  parameter logic [NUM_CHANNELS*7-1:0]   CHANNEL_ADDRS = {XADC_ADDR_VAUX12, XADC_ADDR_VAUX4},
  parameter int                          DRDY_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        xadc_eos,
  output logic [6:0]  xadc_daddr,
  output logic        xadc_den,
  input  logic        xadc_drdy,
  input  logic [15:0] xadc_do,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] overrun_count,
  output logic [15:0] timeout_count,
  output logic        busy
);

  localparam int CH_W = ch_width(NUM_CHANNELS);
  localparam int TO_W = $clog2(DRDY_TIMEOUT + 1);

  localparam logic [CH_W-1:0] LAST_CH     = CH_W'(NUM_CHANNELS - 1);
  localparam logic [TO_W-1:0] TO_LAST_CNT = TO_W'(DRDY_TIMEOUT - 1);

  // Table lookup that never indexes past the table, even for index values
  // that a small channel count cannot reach.
  function automatic logic [6:0] chan_addr(input logic [CH_W-1:0] idx);
    logic [6:0] addr;
    addr = CHANNEL_ADDRS[6:0];
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (idx == CH_W'(i)) begin
        addr = CHANNEL_ADDRS[i*7 +: 7];
      end
    end
    return addr;
  endfunction

  sampler_state_t    state_q;
  logic [CH_W-1:0]   ch_q;
  logic [TO_W-1:0]   wait_cnt_q;
  logic [6:0]        daddr_q;
  logic              den_q;
  logic [15:0]       tdata_q;
  logic              tvalid_q;
  logic              busy_q;
`ifdef XADC_SAMPLER_TLAST_EN
  logic              tlast_q;
`endif

  logic [SAMPLE_WIDTH-1:0] sample;
  logic                    overrun_inc;
  logic                    timeout_inc;
  logic                    unused_do;

  // Keep the result MSBs; low-order DRP bits are below the converter resolution.
  assign sample    = xadc_do[XADC_RESULT_MSB -: SAMPLE_WIDTH];
  assign unused_do = ^xadc_do;

  // An EOS that cannot start a sequence is only an overrun if the block is
  // enabled; this includes an EOS coinciding with the final handshake.
  assign overrun_inc = xadc_eos && enable && (state_q != IDLE);
  assign timeout_inc = (state_q == WAIT_DRDY) && !xadc_drdy && (wait_cnt_q == TO_LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      wait_cnt_q <= '0;
      daddr_q    <= CHANNEL_ADDRS[6:0];
      den_q      <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef XADC_SAMPLER_TLAST_EN
      tlast_q    <= 1'b0;
`endif
    end else begin
      den_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xadc_eos && enable) begin
            ch_q    <= '0;
            daddr_q <= chan_addr('0);
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end

        // The den pulse is registered here, so it is seen on the bus during
        // the first WAIT_DRDY cycle with daddr already stable.
        ISSUE: begin
          den_q      <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= WAIT_DRDY;
        end

        WAIT_DRDY: begin
          if (xadc_drdy) begin
            tdata_q  <= {4'(ch_q), 12'(sample)};
            tvalid_q <= 1'b1;
`ifdef XADC_SAMPLER_TLAST_EN
            tlast_q  <= (ch_q == LAST_CH);
`endif
            state_q  <= SEND;
          end else if (wait_cnt_q == TO_LAST_CNT) begin
            // Abandon the rest of the sequence; the next EOS restarts at ch 0.
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
          end
        end

        SEND: begin
          if (m_axis_tready) begin
            tvalid_q <= 1'b0;
            if (ch_q == LAST_CH) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              ch_q    <= ch_q + CH_W'(1);
              daddr_q <= chan_addr(ch_q + CH_W'(1));
              state_q <= ISSUE;
            end
          end
        end

        default: begin
          tvalid_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(16)) u_overrun_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (overrun_inc),
    .count (overrun_count)
  );

  sat_counter #(.WIDTH(16)) u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (timeout_inc),
    .count (timeout_count)
  );

  assign xadc_daddr    = daddr_q;
  assign xadc_den      = den_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;
`ifdef XADC_SAMPLER_TLAST_EN
  assign m_axis_tlast  = tlast_q;
`else
  assign m_axis_tlast  = 1'b0;
`endif

endmodule

// File: tb/tb_xadc_drp_sampler.sv
// tb/tb_xadc_drp_sampler.sv - scoreboard bench for xadc_drp_sampler
module tb_xadc_drp_sampler;

`ifdef XADC_SAMPLER_TLAST_EN
  localparam bit TLAST_ON = 1'b1;
`else
  localparam bit TLAST_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, xadc_eos, xadc_drdy, m_axis_tready;
  logic [15:0] xadc_do;
  logic [6:0]  xadc_daddr;
  logic        xadc_den, m_axis_tvalid, m_axis_tlast, busy;
  logic [15:0] m_axis_tdata, overrun_count, timeout_count;

  logic        eos8, drdy8, den8, tvalid8, tlast8, busy8;
  logic [15:0] do8, tdata8, ovr8, to8;
  logic [6:0]  daddr8;

  int          compared   = 0;
  int          mismatched = 0;
  int          beats_seen = 0;
  int          den_seen   = 0;
  logic [16:0] exp_q[$];
  bit          drp_dead   = 1'b0;

  // Channel 0 reads 7'h1c, channel 1 reads 7'h14.
  xadc_drp_sampler #(
    .NUM_CHANNELS (2),
    .SAMPLE_WIDTH (12),
    .CHANNEL_ADDRS({7'h14, 7'h1c}),
    .DRDY_TIMEOUT (64)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .xadc_eos(xadc_eos),
    .xadc_daddr(xadc_daddr), .xadc_den(xadc_den), .xadc_drdy(xadc_drdy), .xadc_do(xadc_do),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .overrun_count(overrun_count), .timeout_count(timeout_count),
    .busy(busy)
  );

  xadc_drp_sampler #(
    .NUM_CHANNELS (1),
    .SAMPLE_WIDTH (8),
    .CHANNEL_ADDRS(7'h1c),
    .DRDY_TIMEOUT (64)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n), .enable(1'b1), .xadc_eos(eos8),
    .xadc_daddr(daddr8), .xadc_den(den8), .xadc_drdy(drdy8), .xadc_do(do8),
    .m_axis_tdata(tdata8), .m_axis_tvalid(tvalid8), .m_axis_tready(1'b1),
    .m_axis_tlast(tlast8), .overrun_count(ovr8), .timeout_count(to8),
    .busy(busy8)
  );

  function automatic logic [15:0] drp_data(input logic [6:0] addr);
    case (addr)
      7'h1c:   return 16'hABC0;
      7'h14:   return 16'h1230;
      default: return 16'hDEAD;
    endcase
  endfunction

  // DRP model: drdy two cycles after den, silent when drp_dead.
  logic       pend;
  logic [6:0] pend_addr;
  always @(posedge clk) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      xadc_drdy <= 1'b0;
      xadc_do   <= 16'h0000;
    end else begin
      pend      <= xadc_den && !drp_dead;
      pend_addr <= xadc_daddr;
      xadc_drdy <= pend;
      if (pend) xadc_do <= drp_data(pend_addr);
    end
  end

  logic pend8;
  assign do8 = 16'hFFF0;
  always @(posedge clk) begin
    if (!rst_n) begin
      pend8 <= 1'b0;
      drdy8 <= 1'b0;
    end else begin
      pend8 <= den8;
      drdy8 <= pend8;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop and compare on every handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      beats_seen++;
      check("beat_was_expected", 16'(exp_q.size() != 0), 16'd1);
      if (exp_q.size() != 0) begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("beat_tdata", m_axis_tdata, e[15:0]);
        check("beat_tlast", 16'(m_axis_tlast), 16'(e[16]));
      end
    end
    if (rst_n === 1'b1 && xadc_den === 1'b1) den_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_eos();
    xadc_eos = 1'b1;
    tick();
    xadc_eos = 1'b0;
  endtask

  task automatic push_seq();
    exp_q.push_back({1'b0, 16'h0ABC});
    exp_q.push_back({TLAST_ON, 16'h1123});
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, 16'(busy), 16'd0);
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    int n = 0;
    while (m_axis_tvalid !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, 16'(m_axis_tvalid), 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int d0;
    int b0;

    rst_n = 1'b0; enable = 1'b0; xadc_eos = 1'b0; m_axis_tready = 1'b0; eos8 = 1'b0;
    repeat (3) tick();
    check("rst_tvalid",  16'(m_axis_tvalid), 16'd0);
    check("rst_tdata",   m_axis_tdata,       16'h0000);
    check("rst_tlast",   16'(m_axis_tlast),  16'd0);
    check("rst_den",     16'(xadc_den),      16'd0);
    check("rst_daddr",   16'(xadc_daddr),    16'h001c);
    check("rst_overrun", overrun_count,      16'd0);
    check("rst_timeout", timeout_count,      16'd0);
    check("rst_busy",    16'(busy),          16'd0);

    rst_n = 1'b1; enable = 1'b1; m_axis_tready = 1'b1;
    tick();

    // Basic two-channel sequence with free-flowing output.
    push_seq();
    pulse_eos();
    check("busy_after_eos", 16'(busy), 16'd1);
    wait_idle("seq1_idle", 100);
    check("seq1_beats",   16'(beats_seen),   16'd2);
    check("seq1_den",     16'(den_seen),     16'd2);
    check("seq1_drained", 16'(exp_q.size()), 16'd0);

    // Eight-bit sample width keeps the top byte of the result.
    eos8 = 1'b1;
    tick();
    eos8 = 1'b0;
    n = 0;
    while (tvalid8 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("w8_tvalid", 16'(tvalid8), 16'd1);
    check("w8_tdata",  tdata8,       16'h00FF);
    check("w8_tlast",  16'(tlast8),  16'(TLAST_ON));

    // Backpressure on beat 0: output held, no further DRP read.
    m_axis_tready = 1'b0;
    push_seq();
    pulse_eos();
    wait_valid("bp_valid", 20);
    d0 = den_seen;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_tvalid_held",  16'(m_axis_tvalid), 16'd1);
      check("bp_tdata_stable", m_axis_tdata,       exp_q[0][15:0]);
    end
    check("bp_no_second_den", 16'(den_seen), 16'(d0));
    m_axis_tready = 1'b1;
    wait_idle("bp_idle", 100);
    check("bp_beats", 16'(beats_seen), 16'd4);

    // Three EOS pulses while stalled count as overruns.
    m_axis_tready = 1'b0;
    push_seq();
    pulse_eos();
    wait_valid("ovr_valid", 20);
    for (int i = 0; i < 3; i++) begin
      pulse_eos();
      tick();
    end
    check("ovr_count", overrun_count, 16'd3);
    m_axis_tready = 1'b1;
    wait_idle("ovr_idle", 100);
    check("ovr_beats",       16'(beats_seen), 16'd6);
    check("ovr_count_after", overrun_count,   16'd3);

    // DRP never answers: sequence abandoned after the timeout.
    drp_dead = 1'b1;
    b0 = beats_seen;
    pulse_eos();
    repeat (40) tick();
    check("to_still_waiting", 16'(busy), 16'd1);
    wait_idle("to_idle", 100);
    check("to_count",     timeout_count,   16'd1);
    check("to_no_beat",   16'(beats_seen), 16'(b0));
    drp_dead = 1'b0;
    push_seq();
    pulse_eos();
    wait_idle("to_recover_idle", 100);
    check("to_recover_beats", 16'(beats_seen), 16'(b0 + 2));
    check("to_count_after",   timeout_count,   16'd1);

    // Asynchronous reset while a beat is stalled.
    m_axis_tready = 1'b0;
    push_seq();
    pulse_eos();
    wait_valid("rst_mid_valid", 20);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tvalid",  16'(m_axis_tvalid), 16'd0);
    check("rst_mid_overrun", overrun_count,      16'd0);
    check("rst_mid_timeout", timeout_count,      16'd0);
    check("rst_mid_busy",    16'(busy),          16'd0);
    exp_q.delete();
    b0 = beats_seen;
    tick();
    tick();
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    repeat (30) tick();
    check("rst_mid_no_residual", 16'(beats_seen), 16'(b0));

    // Disabled: EOS neither starts a read nor counts.
    enable = 1'b0;
    d0 = den_seen;
    pulse_eos();
    repeat (20) tick();
    check("dis_no_den",     16'(den_seen),   16'(d0));
    check("dis_no_overrun", overrun_count,   16'd0);
    check("dis_busy",       16'(busy),       16'd0);
    check("dis_no_beat",    16'(beats_seen), 16'(b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
